multicycle_control_unit: RTL

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/multicycle_control_unit.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_unit.sv
// Multicycle RISC-style control FSM: IDLE/FETCH/DECODE/EXEC/MEM/WB/TRAP.
// Define CU_ILLEGAL_TRAP_EN to trap on illegal opcodes (default: NOP).
module multicycle_control_unit #(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic [OP_W-1:0]    opcode,
    input  logic               mem_ready,
    output logic [1:0]         reg_dst,
    output logic               reg_write,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               mem_read,
    output logic               mem_write,
    output logic [1:0]         branch_op,
    output logic               alu_src,
    output logic [1:0]         pc_mem_reg,
    output logic               pc_write,
    output logic               ir_write,
    output logic [2:0]         state,
    output logic               illegal_op
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd6;

    localparam logic [2:0] C_ALUR = 3'd0;
    localparam logic [2:0] C_BR   = 3'd1;
    localparam logic [2:0] C_JAL  = 3'd2;
    localparam logic [2:0] C_ALUI = 3'd3;
    localparam logic [2:0] C_LD   = 3'd4;
    localparam logic [2:0] C_ST   = 3'd5;
    localparam logic [2:0] C_ILL  = 3'd6;

    function automatic logic [2:0] classify(input logic [OP_W-1:0] op);
        logic [2:0] c;
        c = C_ILL;
        if (op < OP_W'(4)) c = C_ALUR;
        else if (op == OP_W'(4) || op == OP_W'(5)) c = C_BR;
        else if (op == OP_W'(6)) c = C_JAL;
        else if (op == OP_W'(60) || op == OP_W'(61)) c = C_ALUI;
        else if (op == OP_W'(62)) c = C_LD;
        else if (op == OP_W'(63)) c = C_ST;
        return c;
    endfunction

    logic [2:0]      state_q, state_d;
    logic [OP_W-1:0] op_q, op_d;
    logic [2:0]      cls_in, cls_q;
    logic [2:0]      alu_v;

    assign cls_in = classify(opcode);
    assign cls_q  = classify(op_q);
    assign state  = state_q;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE:   if (run) state_d = S_FETCH;
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                op_d = opcode;
                case (cls_in)
                    C_JAL:   state_d = S_WB;
`ifdef CU_ILLEGAL_TRAP_EN
                    C_ILL:   state_d = S_TRAP;
`else
                    C_ILL:   state_d = S_FETCH;
`endif
                    default: state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (cls_q)
                    C_BR:       state_d = S_FETCH;
                    C_LD, C_ST: state_d = S_MEM;
                    default:    state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_ready)
                    state_d = (cls_q == C_LD) ? S_WB : S_FETCH;
            end
            S_WB:     state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

`ifdef CU_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;

    always_comb begin
        illegal_d = illegal_q;
        if (state_q == S_DECODE && cls_in == C_ILL) illegal_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) illegal_q <= 1'b0;
        else        illegal_q <= illegal_d;
    end

    assign illegal_op = illegal_q;
`else
    assign illegal_op = 1'b0;
`endif

    // Moore decode; only FETCH's load pulses look at mem_ready
    always_comb begin
        reg_dst    = 2'd0;
        reg_write  = 1'b0;
        alu_v      = 3'd0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        branch_op  = 2'd0;
        alu_src    = 1'b0;
        pc_mem_reg = 2'd0;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            S_EXEC: begin
                case (cls_q)
                    C_ALUR: begin
                        case (op_q[1:0])
                            2'd0:    alu_v = 3'd1;
                            2'd1:    alu_v = 3'd3;
                            2'd2:    alu_v = 3'd5;
                            default: alu_v = 3'd6;
                        endcase
                    end
                    C_ALUI: begin
                        alu_src = 1'b1;
                        alu_v   = op_q[0] ? 3'd4 : 3'd2;
                    end
                    C_LD, C_ST: begin
                        alu_src = 1'b1;
                        alu_v   = 3'd2;
                    end
                    C_BR: begin
                        branch_op = op_q[0] ? 2'd2 : 2'd1;
                        pc_write  = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                alu_src   = 1'b1;
                alu_v     = 3'd2;
                mem_read  = (cls_q == C_LD);
                mem_write = (cls_q == C_ST);
            end
            S_WB: begin
                reg_write = 1'b1;
                if (cls_q == C_LD) begin
                    reg_dst    = 2'd2;
                    pc_mem_reg = 2'd1;
                end else if (cls_q == C_JAL) begin
                    reg_dst    = 2'd1;
                    pc_mem_reg = 2'd2;
                    branch_op  = 2'd3;
                    pc_write   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign alu_op = ALUOP_W'(alu_v);

endmodule
